// File: rtl/dispense_sequencer.sv
// Servo gate dispense sequencer: open, hold, close via a PWM pulse-train
// generator, with a one-deep request queue and a fault trap.
module dispense_sequencer #(
  parameter logic [10:0] OPEN_WIDTH  = 11'd2000,
  parameter logic [10:0] CLOSE_WIDTH = 11'd1000,
  parameter int unsigned HOLD_CYCLES = 500000
) (
  input  logic        clk_1M,
  input  logic        rst_n,
  input  logic        dispense_req,
  input  logic        clear_fault,
  input  logic        train_idle,
  output logic        train_req,
  output logic [10:0] train_width,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] dispense_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OPEN_REQ,
    S_OPEN_ACK,
    S_OPEN_WAIT,
    S_HOLD,
    S_CLOSE_REQ,
    S_CLOSE_ACK,
    S_CLOSE_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [19:0] hold_q, hold_d;
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      hold_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    count_d   = count_q;
    // Requests arriving mid-sequence queue one more run
    if (dispense_req && state_q != S_IDLE && state_q != S_FAULT)
      pending_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if ((dispense_req || pending_q) && train_idle) begin
          state_d   = S_OPEN_REQ;
          pending_d = 1'b0;
        end
      end
      S_OPEN_REQ:  state_d = S_OPEN_ACK;
      S_OPEN_ACK:  state_d = train_idle ? S_FAULT : S_OPEN_WAIT;
      S_OPEN_WAIT: begin
        if (train_idle) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = S_CLOSE_REQ;
        else              hold_d  = hold_q - 20'd1;
      end
      S_CLOSE_REQ:  state_d = S_CLOSE_ACK;
      S_CLOSE_ACK:  state_d = train_idle ? S_FAULT : S_CLOSE_WAIT;
      S_CLOSE_WAIT: if (train_idle) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      S_FAULT: begin
        pending_d = 1'b0;
        if (clear_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    train_req   = (state_q == S_OPEN_REQ) || (state_q == S_CLOSE_REQ);
    train_width = CLOSE_WIDTH;
    // Width stays open for the whole opening pulse train and hold
    if (state_q == S_OPEN_REQ || state_q == S_OPEN_ACK ||
        state_q == S_OPEN_WAIT || state_q == S_HOLD)
      train_width = OPEN_WIDTH;
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    fault          = (state_q == S_FAULT);
    dispense_count = count_q;
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer against a cycle timeline
// model of open/hold/close sequences with a modelled pulse-train generator.
`timescale 1ns/1ps
module tb_dispense_sequencer;

  localparam int HOLD = 4;
  localparam int SEQ  = 11 + HOLD;
  localparam logic [10:0] OPW = 11'd2000;
  localparam logic [10:0] CLW = 11'd1000;

  logic        clk_1M = 1'b0;
  logic        rst_n = 1'b0;
  logic        dispense_req = 1'b0;
  logic        clear_fault = 1'b0;
  logic        train_idle;
  logic        train_req;
  logic [10:0] train_width;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] dispense_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int gen_cnt = 0;
  bit gen_en = 1'b1;
  bit idle_low = 1'b0;

  dispense_sequencer #(
    .OPEN_WIDTH(OPW),
    .CLOSE_WIDTH(CLW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_1M(clk_1M),
    .rst_n(rst_n),
    .dispense_req(dispense_req),
    .clear_fault(clear_fault),
    .train_idle(train_idle),
    .train_req(train_req),
    .train_width(train_width),
    .busy(busy),
    .done(done),
    .fault(fault),
    .dispense_count(dispense_count)
  );

  always #500 clk_1M = ~clk_1M;

  // Generator: goes non-idle for 3 cycles after accepting a request
  assign train_idle = !idle_low && (gen_cnt == 0);
  always @(posedge clk_1M) begin
    if (gen_en && train_req) gen_cnt <= 3;
    else if (gen_cnt > 0)    gen_cnt <= gen_cnt - 1;
  end

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Sequence starting at cycle s: offset 0 open req, 5..4+HOLD hold,
  // 5+HOLD close req, SEQ-1 done.
  task automatic run_timeline(input int ncyc, input int prob,
                              input int fixed[$]);
    int s = -1000;
    bit pend = 1'b0;
    int off;
    bit r, eb, er, ed;
    logic [10:0] ew;
    for (int c = 0; c < ncyc + 2 * SEQ + 4; c++) begin
      @(negedge clk_1M);
      off = c - s;
      eb = (off >= 0) && (off < SEQ);
      er = (off == 0) || (off == 5 + HOLD);
      ed = (off == SEQ - 1);
      ew = (off >= 0 && off <= 4 + HOLD) ? OPW : CLW;
      checks++;
      if ({busy, train_req, done, fault, train_width, dispense_count} !==
          {eb, er, ed, 1'b0, ew, exp_count[15:0]}) begin
        errors++;
        $display("FAIL timeline c=%0d got b%b r%b d%b f%b w%0d n%0h exp b%b r%b d%b f0 w%0d n%0h",
                 c, busy, train_req, done, fault, train_width,
                 dispense_count, eb, er, ed, ew, exp_count[15:0]);
      end
      r = 1'b0;
      if (c < ncyc) begin
        if (prob > 0) r = ($urandom_range(0, 99) < prob);
        else foreach (fixed[i]) if (fixed[i] == c) r = 1'b1;
      end
      dispense_req = r;
      if (eb) begin
        if (r) pend = 1'b1;
      end else if (r || pend) begin
        s = c + 1;
        pend = 1'b0;
      end
      if (ed) exp_count = sat_inc(exp_count);
    end
    dispense_req = 1'b0;
  endtask

  task automatic test_reset;
    #200;
    checks++;
    if ({busy, train_req, done, fault, train_width, dispense_count} !==
        {4'b0000, CLW, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state got b%b r%b d%b f%b w%0d n%0h", busy,
               train_req, done, fault, train_width, dispense_count);
    end
    @(negedge clk_1M);
    rst_n = 1'b1;
    @(negedge clk_1M);
    checks++;
    if (busy !== 1'b0 || dispense_count !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_idle got b%b n%0h exp b0 n0", busy,
               dispense_count);
    end
  endtask

  task automatic test_single;
    int q[$] = '{0};
    run_timeline(1, 0, q);
    checks++;
    if (dispense_count !== 16'd1) begin
      errors++;
      $display("FAIL single_count got %0d exp 1", dispense_count);
    end
  endtask

  task automatic test_pending;
    int q[$] = '{0, 7, 13};
    run_timeline(14, 0, q);
    checks++;
    if (dispense_count !== 16'd3) begin
      errors++;
      $display("FAIL pending_count got %0d exp 3", dispense_count);
    end
  endtask

  task automatic test_clear_idle;
    @(negedge clk_1M);
    clear_fault = 1'b1;
    @(negedge clk_1M);
    clear_fault = 1'b0;
    checks++;
    if (busy !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_idle got b%b f%b exp b0 f0", busy, fault);
    end
  endtask

  task automatic test_wait_idle;
    idle_low = 1'b1;
    @(negedge clk_1M);
    dispense_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_1M);
      checks++;
      if (train_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL held_off i=%0d got r%b b%b exp r0 b0", i,
                 train_req, busy);
      end
    end
    idle_low = 1'b0;
    @(negedge clk_1M);
    dispense_req = 1'b0;
    checks++;
    if (train_req !== 1'b1 || train_width !== OPW) begin
      errors++;
      $display("FAIL release_req got r%b w%0d exp r1 w%0d", train_req,
               train_width, OPW);
    end
    for (int i = 0; i < 4 * SEQ && busy; i++) @(negedge clk_1M);
    exp_count = sat_inc(exp_count);
    checks++;
    if (busy !== 1'b0 || dispense_count !== exp_count[15:0]) begin
      errors++;
      $display("FAIL wait_idle_end got b%b n%0d exp b0 n%0d", busy,
               dispense_count, exp_count);
    end
  endtask

  task automatic test_fault;
    gen_en = 1'b0;
    @(negedge clk_1M);
    dispense_req = 1'b1;
    @(negedge clk_1M);
    dispense_req = 1'b0;
    checks++;
    if (train_req !== 1'b1) begin
      errors++;
      $display("FAIL fault_open_req got %b exp 1", train_req);
    end
    @(negedge clk_1M);
    @(negedge clk_1M);
    for (int i = 0; i < 6; i++) begin
      dispense_req = (i == 1 || i == 2);
      checks++;
      if ({fault, busy, train_req, done, train_width} !==
          {4'b1100, CLW}) begin
        errors++;
        $display("FAIL in_fault i=%0d got f%b b%b r%b d%b w%0d", i, fault,
                 busy, train_req, done, train_width);
      end
      @(negedge clk_1M);
    end
    dispense_req = 1'b0;
    gen_en = 1'b1;
    clear_fault = 1'b1;
    @(negedge clk_1M);
    clear_fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({fault, busy, dispense_count} !== {2'b00, exp_count[15:0]}) begin
        errors++;
        $display("FAIL fault_cleared i=%0d got f%b b%b n%0d exp f0 b0 n%0d",
                 i, fault, busy, dispense_count, exp_count);
      end
      @(negedge clk_1M);
    end
  endtask

  task automatic test_random;
    int q[$];
    run_timeline(300, 12, q);
  endtask

  task automatic test_saturate;
    int q[$] = '{0, 20};
    @(negedge clk_1M);
    force dut.count_q = 16'hFFFE;
    #10;
    release dut.count_q;
    exp_count = 16'hFFFE;
    run_timeline(21, 0, q);
    checks++;
    if (dispense_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate got %0h exp ffff", dispense_count);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_1M);
    dispense_req = 1'b1;
    @(negedge clk_1M);
    dispense_req = 1'b0;
    @(negedge clk_1M);
    @(negedge clk_1M);
    checks++;
    if (busy !== 1'b1 || train_width !== OPW || train_idle !== 1'b0) begin
      errors++;
      $display("FAIL open_wait_reached got b%b w%0d i%b", busy,
               train_width, train_idle);
    end
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if ({busy, train_req, done, fault, train_width, dispense_count} !==
        {4'b0000, CLW, 16'h0000}) begin
      errors++;
      $display("FAIL mid_reset got b%b r%b d%b f%b w%0d n%0h", busy,
               train_req, done, fault, train_width, dispense_count);
    end
    @(negedge clk_1M);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !train_idle; i++) @(negedge clk_1M);
    checks++;
    if (train_idle !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got i%b b%b d%b exp i1 b0 d0",
               train_idle, busy, done);
    end
    dispense_req = 1'b1;
    @(negedge clk_1M);
    dispense_req = 1'b0;
    checks++;
    if (train_req !== 1'b1 || train_width !== OPW ||
        dispense_count !== 16'h0) begin
      errors++;
      $display("FAIL restart got r%b w%0d n%0d exp r1 w%0d n0", train_req,
               train_width, dispense_count, OPW);
    end
    for (int i = 0; i < 4 * SEQ && busy; i++) @(negedge clk_1M);
    checks++;
    if (busy !== 1'b0 || dispense_count !== 16'd1) begin
      errors++;
      $display("FAIL restart_end got b%b n%0d exp b0 n1", busy,
               dispense_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_clear_idle();
    test_wait_idle();
    test_fault();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
